camera_ctrl_fsm: RTL and testbench
==================================

Name: camera_ctrl_fsm

Overview:
Top-level control FSM for the pixel-array camera.
- Holds the user-adjustable exposure time and drives the exposure timer (set_time, enable, exp_time), consuming its exposure_done.
- Sequences the pixel-array control lines: erase, expose, nre_1/nre_2 (active-low row enables) and the adc strobe.
- Sits directly upstream of timer_counter and the pixel array/ADC.

Parameters:
EXP_W, 5, width of the exposure-time register and timer init bus
EXP_MIN, 2, lowest allowed exposure time (timer units)
EXP_MAX, 30, highest allowed exposure time
EXP_DEFAULT, 10, exposure time after reset

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
init  in  1  start-capture request, synchronous level, sampled each clk
exp_increase  in  1  increment exposure time request
exp_decrease  in  1  decrement exposure time request
exposure_done  in  1  from timer_counter, high when count reached 0
set_time  out  1  to timer: load exp_time
enable  out  1  to timer: count down
exp_time  out  EXP_W  to timer init; current exposure setting
erase  out  1  pixel erase, high in IDLE
expose  out  1  pixel integrate, high in EXPOSURE
nre_1  out  1  row-1 read enable, active-low
nre_2  out  1  row-2 read enable, active-low
adc  out  1  ADC sample strobe, one-cycle pulse per row

Behaviour:
- States: IDLE, EXPOSURE, READOUT. The 3-bit readout phase counter rd_ph runs 0..5.
- All outputs are Moore-decoded from the registered state, rd_ph and exp_time. There is no combinational path from inputs to outputs.
- Reset (async, any state): state=IDLE, rd_ph=0, exp_time=EXP_DEFAULT.
  - Output values in reset: set_time=1, enable=0, erase=1, expose=0, nre_1=1, nre_2=1, adc=0.
- IDLE:
  - Outputs: erase=1, set_time=1, enable=0, expose=0, nre_1=nre_2=1, adc=0.
  - If init=1: go to EXPOSURE next edge. exp_increase/exp_decrease are ignored that cycle, so init has priority.
  - Otherwise, exp_increase alone: exp_time += 1, saturating at EXP_MAX.
  - Otherwise, exp_decrease alone: exp_time -= 1, saturating at EXP_MIN.
  - Both asserted: no change.
  - Buttons are level inputs. Each cycle they are held, the value steps once.
- EXPOSURE:
  - Outputs: expose=1, enable=1, erase=0, set_time=0.
  - All of init, exp_increase and exp_decrease are ignored; exp_time is frozen.
  - On exposure_done=1: go to READOUT with rd_ph=0.
  - With timer_counter, expose is high for exactly exp_time+2 cycles: the timer loads exp_time+1 on the IDLE→EXPOSURE edge, then needs exp_time+1 decrements plus one cycle to register done.
- READOUT:
  - Outputs: erase=0, expose=0, set_time=0, enable=0.
  - rd_ph increments every cycle.
  - nre_1=0 for rd_ph 0..2; nre_2=0 for rd_ph 3..5.
  - adc=1 only at rd_ph 1 and 4.
  - After rd_ph=5: go to IDLE with rd_ph=0. READOUT lasts exactly 6 cycles.
  - init and the buttons are ignored in READOUT.
- Invariants:
  - nre_1 and nre_2 are never both 0.
  - adc=1 only when exactly one nre is 0.
  - erase and expose are never both 1.
- If exposure_done is already 1 on entry to EXPOSURE (timer fault), the FSM still leaves EXPOSURE on the next edge. No lockup is possible.
- Reset asserted mid-EXPOSURE or mid-READOUT: outputs go to reset values immediately (asynchronous), and any capture in progress is abandoned.
- exp_time is always within [EXP_MIN, EXP_MAX].

Decomposition:
- camera_pkg holds:
  - the state_t enum (IDLE, EXPOSURE, READOUT);
  - the EXP_MIN, EXP_MAX and EXP_DEFAULT constants;
  - the readout phase constants: RD_ROW1_LAST=2, RD_LAST=5, ADC phases 1 and 4.
- One sub-module, exp_time_reg: the saturating up/down exposure register, with load gated by state==IDLE.
- The FSM and readout phase counter stay in camera_ctrl_fsm. The bench instantiates camera_ctrl_fsm together with timer_counter.

Test Plan:
1. Reset: assert reset mid-READOUT (rd_ph=3) → same cycle nre_2=1, erase=1, set_time=1, adc=0; after release, exp_time=10 and state IDLE.
2. Full capture, default 10: one-cycle init pulse → expose=1 for 12 cycles, then nre_1=0 ×3 with adc at the 2nd, nre_2=0 ×3 with adc at the 5th, then erase=1.
3. Saturation: exp_increase held 25 cycles from 10 → exp_time=30 and stays. exp_decrease held 40 cycles → exp_time=2. Capture at 2 → expose high 4 cycles.
4. Priority and conflicts:
   - init + exp_increase in the same cycle → capture starts, exp_time unchanged at 10.
   - exp_increase + exp_decrease together in IDLE → no change.
5. Lockout: exp_increase pulsed during EXPOSURE and init held high throughout READOUT → exp_time unchanged. With init still high, a new capture starts on the first IDLE cycle after READOUT.
6. Invariant checks via assertions on all runs:
   - nre_1 and nre_2 never both 0;
   - erase and expose never both 1;
   - adc pulses only while one nre is low;
   - exp_time always within 2..30.

Source files
------------

// File: rtl/camera_pkg.sv
// Shared types and constants for the camera control slice: FSM states,
// exposure-time limits and readout phase markers.
package camera_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EXPOSURE = 2'd1,
    READOUT  = 2'd2
  } state_t;

  localparam int EXP_W       = 5;
  localparam int EXP_MIN     = 2;
  localparam int EXP_MAX     = 30;
  localparam int EXP_DEFAULT = 10;

  // Readout runs phases 0..RD_LAST; row 1 owns 0..RD_ROW1_LAST, row 2 the rest.
  localparam logic [2:0] RD_ROW1_LAST = 3'd2;
  localparam logic [2:0] RD_LAST      = 3'd5;
  localparam logic [2:0] RD_ADC_ROW1  = 3'd1;
  localparam logic [2:0] RD_ADC_ROW2  = 3'd4;

endpackage

// File: rtl/exp_time_reg.sv
// Saturating up/down exposure-time register; steps once per cycle while a
// single button is held and load_en is high.
module exp_time_reg #(
  parameter int EXP_W = 5,
  parameter logic [EXP_W-1:0] EXP_MIN = EXP_W'(2),
  parameter logic [EXP_W-1:0] EXP_MAX = EXP_W'(30),
  parameter logic [EXP_W-1:0] EXP_DEFAULT = EXP_W'(10)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_en,
  input  logic             inc,
  input  logic             dec,
  output logic [EXP_W-1:0] exp_time
);

  // Both buttons together cancel out; limits clamp rather than wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_time <= EXP_DEFAULT;
    end else if (load_en) begin
      if (inc && !dec && (exp_time < EXP_MAX)) begin
        exp_time <= exp_time + 1'b1;
      end else if (dec && !inc && (exp_time > EXP_MIN)) begin
        exp_time <= exp_time - 1'b1;
      end
    end
  end

endmodule

// File: rtl/timer_counter.sv
// Exposure down-counter: loads init_time+1 while set_time is high, counts
// down while enable is high, and flags exposure_done once it reaches zero.
module timer_counter #(
  parameter int EXP_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set_time,
  input  logic             enable,
  input  logic [EXP_W-1:0] init_time,
  output logic             exposure_done
);

  logic [EXP_W:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (set_time) begin
      count <= {1'b0, init_time} + 1'b1;
    end else if (enable && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign exposure_done = (count == '0);

endmodule

// File: rtl/camera_ctrl_fsm.sv
// Top-level camera control FSM: owns the exposure setting, drives the timer
// and sequences erase/expose/row-enable/ADC lines for one capture.
module camera_ctrl_fsm #(
  parameter int EXP_W = camera_pkg::EXP_W,
  parameter logic [EXP_W-1:0] EXP_MIN = EXP_W'(camera_pkg::EXP_MIN),
  parameter logic [EXP_W-1:0] EXP_MAX = EXP_W'(camera_pkg::EXP_MAX),
  parameter logic [EXP_W-1:0] EXP_DEFAULT = EXP_W'(camera_pkg::EXP_DEFAULT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init,
  input  logic             exp_increase,
  input  logic             exp_decrease,
  input  logic             exposure_done,
  output logic             set_time,
  output logic             enable,
  output logic [EXP_W-1:0] exp_time,
  output logic             erase,
  output logic             expose,
  output logic             nre_1,
  output logic             nre_2,
  output logic             adc
);

  import camera_pkg::*;

  state_t     state, state_nxt;
  logic [2:0] rd_ph, rd_ph_nxt;
  logic       exp_load_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      rd_ph <= 3'd0;
    end else begin
      state <= state_nxt;
      rd_ph <= rd_ph_nxt;
    end
  end

  // rd_ph only advances inside READOUT and is parked at 0 everywhere else.
  always_comb begin
    state_nxt = state;
    rd_ph_nxt = 3'd0;
    case (state)
      IDLE: begin
        if (init) state_nxt = EXPOSURE;
      end
      EXPOSURE: begin
        if (exposure_done) state_nxt = READOUT;
      end
      READOUT: begin
        if (rd_ph == RD_LAST) begin
          state_nxt = IDLE;
        end else begin
          rd_ph_nxt = rd_ph + 3'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    set_time = 1'b0;
    enable   = 1'b0;
    erase    = 1'b0;
    expose   = 1'b0;
    nre_1    = 1'b1;
    nre_2    = 1'b1;
    adc      = 1'b0;
    case (state)
      IDLE: begin
        set_time = 1'b1;
        erase    = 1'b1;
      end
      EXPOSURE: begin
        enable = 1'b1;
        expose = 1'b1;
      end
      READOUT: begin
        nre_1 = !(rd_ph <= RD_ROW1_LAST);
        nre_2 = !((rd_ph > RD_ROW1_LAST) && (rd_ph <= RD_LAST));
        adc   = (rd_ph == RD_ADC_ROW1) || (rd_ph == RD_ADC_ROW2);
      end
      default: begin
        set_time = 1'b1;
        erase    = 1'b1;
      end
    endcase
  end

  // init wins over the buttons, and the setting is frozen outside IDLE.
  assign exp_load_en = (state == IDLE) && !init;

  exp_time_reg #(
    .EXP_W      (EXP_W),
    .EXP_MIN    (EXP_MIN),
    .EXP_MAX    (EXP_MAX),
    .EXP_DEFAULT(EXP_DEFAULT)
  ) u_exp_time_reg (
    .clk     (clk),
    .reset   (reset),
    .load_en (exp_load_en),
    .inc     (exp_increase),
    .dec     (exp_decrease),
    .exp_time(exp_time)
  );

endmodule

// File: tb/tb_camera_ctrl_fsm.sv
// Directed bench for camera_ctrl_fsm running against timer_counter: IDLE
// button vectors from a table, plus hand-written capture and reset sequences.
module tb_camera_ctrl_fsm;

  logic       clk;
  logic       reset;
  logic       init;
  logic       exp_increase;
  logic       exp_decrease;
  logic       exposure_done;
  logic       set_time;
  logic       enable;
  logic [4:0] exp_time;
  logic       erase;
  logic       expose;
  logic       nre_1;
  logic       nre_2;
  logic       adc;

  int checks = 0;
  int errors = 0;

  camera_ctrl_fsm dut (
    .clk          (clk),
    .reset        (reset),
    .init         (init),
    .exp_increase (exp_increase),
    .exp_decrease (exp_decrease),
    .exposure_done(exposure_done),
    .set_time     (set_time),
    .enable       (enable),
    .exp_time     (exp_time),
    .erase        (erase),
    .expose       (expose),
    .nre_1        (nre_1),
    .nre_2        (nre_2),
    .adc          (adc)
  );

  timer_counter #(.EXP_W(5)) u_timer (
    .clk          (clk),
    .reset        (reset),
    .set_time     (set_time),
    .enable       (enable),
    .init_time    (exp_time),
    .exposure_done(exposure_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       init;
    logic       inc;
    logic       dec;
    logic [4:0] exp_time;
    logic       erase;
  } vec_t;

  vec_t vecs[7];

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic i, input logic u, input logic d);
    init         = i;
    exp_increase = u;
    exp_decrease = d;
    @(posedge clk);
    #1;
  endtask

  // Counts the remaining expose-high cycles starting from the current one.
  task automatic waitExposeEnd(output int n);
    n = 0;
    while (expose && n < 100) begin
      n++;
      applyStimulus(1'b0, 1'b0, 1'b0);
    end
    if (n >= 100) begin
      errors++;
      $display("[TB] FAIL expose_timeout: still high after %0d cycles, required to drop", n);
    end
  endtask

  task automatic checkReadout(input logic hold_init);
    logic exp_nre1[6];
    logic exp_nre2[6];
    logic exp_adc[6];
    exp_nre1 = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    exp_nre2 = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    exp_adc  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 6; k++) begin
      checkOutput($sformatf("rd%0d_nre_1", k), nre_1, exp_nre1[k]);
      checkOutput($sformatf("rd%0d_nre_2", k), nre_2, exp_nre2[k]);
      checkOutput($sformatf("rd%0d_adc", k), adc, exp_adc[k]);
      checkOutput($sformatf("rd%0d_erase", k), erase, 0);
      applyStimulus(hold_init, 1'b0, 1'b0);
    end
    checkOutput("post_readout_erase", erase, 1);
  endtask

  // Invariant monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (!nre_1 && !nre_2) begin
        errors++;
        $display("[TB] FAIL inv_nre: nre_1=%0d nre_2=%0d, required not both 0", nre_1, nre_2);
      end
      if (erase && expose) begin
        errors++;
        $display("[TB] FAIL inv_erase_expose: erase=%0d expose=%0d, required not both 1", erase, expose);
      end
      if (adc && (nre_1 == nre_2)) begin
        errors++;
        $display("[TB] FAIL inv_adc: adc=1 with nre_1=%0d nre_2=%0d, required exactly one low", nre_1, nre_2);
      end
      if (exp_time < 5'd2 || exp_time > 5'd30) begin
        errors++;
        $display("[TB] FAIL inv_exp_range: exp_time=%0d, required 2..30", exp_time);
      end
    end
  end

  initial begin
    int n;

    vecs[0] = '{init: 1'b0, inc: 1'b1, dec: 1'b0, exp_time: 5'd11, erase: 1'b1};
    vecs[1] = '{init: 1'b0, inc: 1'b1, dec: 1'b0, exp_time: 5'd12, erase: 1'b1};
    vecs[2] = '{init: 1'b0, inc: 1'b0, dec: 1'b1, exp_time: 5'd11, erase: 1'b1};
    vecs[3] = '{init: 1'b0, inc: 1'b1, dec: 1'b1, exp_time: 5'd11, erase: 1'b1};
    vecs[4] = '{init: 1'b0, inc: 1'b0, dec: 1'b0, exp_time: 5'd11, erase: 1'b1};
    vecs[5] = '{init: 1'b0, inc: 1'b0, dec: 1'b1, exp_time: 5'd10, erase: 1'b1};
    vecs[6] = '{init: 1'b0, inc: 1'b1, dec: 1'b1, exp_time: 5'd10, erase: 1'b1};

    reset        = 1'b1;
    init         = 1'b0;
    exp_increase = 1'b0;
    exp_decrease = 1'b0;
    #12;
    checkOutput("rst_exp_time", exp_time, 10);
    checkOutput("rst_set_time", set_time, 1);
    checkOutput("rst_enable", enable, 0);
    checkOutput("rst_erase", erase, 1);
    checkOutput("rst_expose", expose, 0);
    checkOutput("rst_nre_1", nre_1, 1);
    checkOutput("rst_nre_2", nre_2, 1);
    checkOutput("rst_adc", adc, 0);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("idle_exp_time", exp_time, 10);

    $display("[TB] IDLE button vectors");
    for (int v = 0; v < 7; v++) begin
      applyStimulus(vecs[v].init, vecs[v].inc, vecs[v].dec);
      checkOutput($sformatf("vec%0d_exp_time", v), exp_time, vecs[v].exp_time);
      checkOutput($sformatf("vec%0d_erase", v), erase, vecs[v].erase);
      checkOutput($sformatf("vec%0d_expose", v), expose, 0);
    end

    $display("[TB] Full capture at default exposure");
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("cap10_expose", expose, 1);
    checkOutput("cap10_enable", enable, 1);
    waitExposeEnd(n);
    checkOutput("cap10_len", n, 12);
    checkReadout(1'b0);

    $display("[TB] init and exp_increase together");
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("prio_expose", expose, 1);
    checkOutput("prio_exp_time", exp_time, 10);
    waitExposeEnd(n);
    checkOutput("prio_len", n, 12);
    checkReadout(1'b0);

    $display("[TB] Lockout during EXPOSURE and READOUT");
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("lock_exp_time_exp", exp_time, 10);
    waitExposeEnd(n);
    checkReadout(1'b1);
    checkOutput("lock_exp_time_rd", exp_time, 10);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("lock_restart_expose", expose, 1);
    waitExposeEnd(n);
    checkOutput("lock_restart_len", n, 12);
    checkReadout(1'b0);

    $display("[TB] Saturation");
    for (int k = 0; k < 25; k++) applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("sat_max", exp_time, 30);
    for (int k = 0; k < 40; k++) applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("sat_min", exp_time, 2);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitExposeEnd(n);
    checkOutput("cap2_len", n, 4);
    checkReadout(1'b0);

    $display("[TB] Reset mid-READOUT");
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitExposeEnd(n);
    checkOutput("mid_len", n, 4);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("mid_rd3_nre_2", nre_2, 0);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_nre_2", nre_2, 1);
    checkOutput("mid_rst_nre_1", nre_1, 1);
    checkOutput("mid_rst_erase", erase, 1);
    checkOutput("mid_rst_set_time", set_time, 1);
    checkOutput("mid_rst_adc", adc, 0);
    checkOutput("mid_rst_exp_time", exp_time, 10);
    #3;
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("post_rst_exp_time", exp_time, 10);
    checkOutput("post_rst_erase", erase, 1);
    checkOutput("post_rst_expose", expose, 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitExposeEnd(n);
    checkOutput("post_rst_len", n, 12);
    checkReadout(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
